npc_bus: RTL and testbench
==========================

// Module: npc_bus
// PURPOSE
//  Slave end of the npc master port driven by the npu core; sits directly downstream of it.
//  - Accepts one burst request at a time (req/gnt) and converts it into single-word
//    accesses on a simple ready/valid memory port.
//  - Returns read data to the core, one npc_ack per 64-bit beat.
//  - A small read-return FIFO decouples memory latency from the core.
// PARAMETERS
//  MAW    14  memory word-address width (mem_adr), i.e. 2^MAW x 64-bit words
//  RDEPTH 4   read-return FIFO depth in words (power of 2); also the max outstanding reads
// PORTS
//  clk       in   1   system clock, all logic on rising edge
//  rst       in   1   asynchronous, active-high reset
//  npc_req   in   1   burst request, held high by the core until npc_gnt
//  npc_gnt   out  1   1-cycle pulse: request accepted, rwn/adr/len latched
//  npc_rwn   in   1   1 = read burst, 0 = write burst
//  npc_adr   in   32  byte address, 8-byte aligned (adr[2:0] ignored)
//  npc_len   in   32  burst length in 64-bit words
//  npc_wdt   in   64  write data for current beat, stable until its npc_ack
//  npc_rdt   out  64  read data, valid only in npc_ack cycles of a read burst
//  npc_ack   out  1   1-cycle pulse per beat completed
//  mem_req   out  1   memory access valid; held with adr/we/wdt until mem_rdy
//  mem_we    out  1   1 = write
//  mem_adr   out  MAW word address
//  mem_wdt   out  64  write data
//  mem_rdy   in   1   memory accepts access this cycle (mem_req & mem_rdy = transfer)
//  mem_rvld  in   1   read data valid, in order, >=1 cycle after accepted read
//  mem_rdt   in   64  read data
//  bus_bsy   out  1   high from npc_gnt until the last npc_ack of the burst
// BEHAVIOUR
//  - Reset: state IDLE; npc_gnt, npc_ack, mem_req, mem_we, bus_bsy = 0; npc_rdt, mem_adr,
//    mem_wdt = 0; FIFO empty; counters 0. Reset mid-burst aborts it; no further acks.
//  - FSM states IDLE, WR, RD, RDRN (read drain):
//    IDLE: npc_req=1 -> npc_gnt=1 for one cycle; latch rwn, wadr = adr[MAW+2:3], cnt = len;
//      len==0 -> stay IDLE, no ack, bus_bsy not asserted; else -> WR (rwn=0) or RD (rwn=1).
//      The cycle after gnt the core has dropped req; npc_req is not re-sampled until IDLE.
//    WR: mem_req=1, mem_we=1, mem_wdt=npc_wdt, mem_adr=wadr. On mem_req&mem_rdy: npc_ack=1
//      the same cycle (registered next-edge pulse not allowed; ack is combinational from
//      rdy & state), wadr++, cnt--. cnt reaches 0 -> IDLE next cycle.
//    RD: mem_req=1, mem_we=0 while issued<len and (outstanding + FIFO occupancy) < RDEPTH.
//      Each accepted read: wadr++, issued++. All issued -> RDRN.
//    RDRN: no mem_req; wait until all returned words are acked -> IDLE.
//    Read return (RD and RDRN): mem_rvld pushes mem_rdt into FIFO; FIFO non-empty ->
//      pop, npc_rdt = head, npc_ack=1 (registered, 1 beat/cycle max). Push and pop in the
//      same cycle both happen. Credit rule guarantees FIFO never overflows.
//  - Latency: gnt 1 cycle after req seen in IDLE; read ack >= 2 cycles after mem_rvld=1
//    of zero-latency memory path (push edge, pop edge).
//  - wadr is MAW bits and wraps 2^MAW-1 -> 0 silently (range check below aside).
//  - cnt/issued are 32 bits; len up to 2^32-1 supported.
//  - mem_rvld outside an outstanding read is ignored (not pushed).
//  - bus_bsy = state != IDLE.
// CONFIGURATION
//  NPC_BUS_RANGE_EN defined: a beat whose word address has npc_adr bits [31:MAW+3] non-zero
//    (base check on latched adr, plus wrap past 2^MAW-1) is not issued to memory; writes are
//    acked and dropped, reads ack with npc_rdt = 64'h0 in order; output bus_err (1 bit)
//    goes sticky 1 until rst. Range-error beats still obey the 1-ack-per-cycle rule.
//  Undefined: no bus_err port; addresses truncated and wrap as above.
// TESTING
//  1 write len=4 adr=0x40, mem_rdy=1 -> 4 acks in 4 consecutive cycles, mem_adr 8,9,10,11.
//  2 read len=3 adr=0x0, mem latency 3, rdy=1 -> npc_rdt = mem words 0,1,2 in order,
//    3 acks, bus_bsy falls after the last ack.
//  3 read len=10, memory stalls rvld 20 cycles -> max 4 outstanding, no FIFO overflow,
//    10 acks, data in order.
//  4 len=0 read -> one gnt, zero acks, bus_bsy stays 0, next req granted normally.
//  5 write at word 2^MAW-1 len=2 -> mem_adr 2^MAW-1 then 0 (RANGE_EN: 2nd beat dropped,
//    bus_err=1).
//  6 rst pulse mid read after 2 of 5 acks -> all outputs 0 next cycle, later rvld ignored.

Source files
------------

// File: rtl/npc_bus.sv
// npc master-port slave: turns req/gnt bursts into single-word ready/valid memory accesses.
// Optional range checking with bus_err output when NPC_BUS_RANGE_EN is defined.
module npc_bus #(
    parameter int MAW    = 14,
    parameter int RDEPTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            npc_req,
    output logic            npc_gnt,
    input  logic            npc_rwn,
    input  logic [31:0]     npc_adr,
    input  logic [31:0]     npc_len,
    input  logic [63:0]     npc_wdt,
    output logic [63:0]     npc_rdt,
    output logic            npc_ack,
    output logic            mem_req,
    output logic            mem_we,
    output logic [MAW-1:0]  mem_adr,
    output logic [63:0]     mem_wdt,
    input  logic            mem_rdy,
    input  logic            mem_rvld,
    input  logic [63:0]     mem_rdt,
    output logic            bus_bsy
`ifdef NPC_BUS_RANGE_EN
    ,
    output logic            bus_err
`endif
);

    // state | meaning
    // IDLE  | waiting for npc_req, grants and latches the burst
    // WR    | one memory write per beat, ack combinational with mem_rdy
    // RD    | issuing reads while credit (outstanding + FIFO) allows
    // RDRN  | all reads issued, draining returned words to the core
    typedef enum logic [1:0] {IDLE, WR, RD, RDRN} state_t;

    localparam int PW = $clog2(RDEPTH);
    localparam int CW = $clog2(RDEPTH) + 1;

    state_t           state_q, state_d;
    logic             gnt_q, gnt_d;
    logic [MAW-1:0]   wadr_q, wadr_d;
    logic [31:0]      cnt_q, cnt_d;
    logic [31:0]      issued_q, issued_d;
    logic [31:0]      rd_left_q, rd_left_d;
    logic [CW-1:0]    outst_q, outst_d;
    logic [CW-1:0]    fcnt_q, fcnt_d;
    logic [PW-1:0]    wptr_q, wptr_d;
    logic [PW-1:0]    rptr_q, rptr_d;
    logic [63:0]      fifo_q [RDEPTH];
    logic [63:0]      fifo_d [RDEPTH];
    logic [63:0]      rdt_q, rdt_d;
    logic             ack_rd_q, ack_rd_d;

    logic step, acc, fake_push, rd_push, push, pop, credit_ok, err_hit, beat_err;

    assign credit_ok = ({1'b0, outst_q} + {1'b0, fcnt_q}) < (CW+1)'(RDEPTH);
    assign rd_push   = mem_rvld && (outst_q != '0);

    always_comb begin
        state_d   = state_q;
        gnt_d     = 1'b0;
        wadr_d    = wadr_q;
        cnt_d     = cnt_q;
        issued_d  = issued_q;
        rd_left_d = rd_left_q;
        fifo_d    = fifo_q;
        wptr_d    = wptr_q;
        rptr_d    = rptr_q;
        ack_rd_d  = 1'b0;
        rdt_d     = '0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_wdt   = '0;
        npc_ack   = ack_rd_q;
        step      = 1'b0;
        acc       = 1'b0;
        fake_push = 1'b0;
        err_hit   = 1'b0;

        case (state_q)
            IDLE: begin
                // gnt_q blocks a re-grant while the core still holds req in the gnt cycle
                if (npc_req && !gnt_q) begin
                    gnt_d     = 1'b1;
                    wadr_d    = npc_adr[MAW+2:3];
                    cnt_d     = npc_len;
                    issued_d  = '0;
                    rd_left_d = npc_len;
                    if (npc_len != '0)
                        state_d = npc_rwn ? RD : WR;
                end
            end
            WR: begin
                if (beat_err) begin
                    npc_ack = 1'b1;
                    step    = 1'b1;
                    err_hit = 1'b1;
                end else begin
                    mem_req = 1'b1;
                    mem_we  = 1'b1;
                    mem_wdt = npc_wdt;
                    if (mem_rdy) begin
                        npc_ack = 1'b1;
                        step    = 1'b1;
                    end
                end
                if (step) begin
                    cnt_d = cnt_q - 32'd1;
                    if (cnt_q == 32'd1)
                        state_d = IDLE;
                end
            end
            RD: begin
                if (issued_q != cnt_q) begin
                    // error beats wait for real reads ahead of them so zeros return in order
                    if (beat_err) begin
                        if (outst_q == '0 && fcnt_q < CW'(RDEPTH)) begin
                            fake_push = 1'b1;
                            step      = 1'b1;
                            err_hit   = 1'b1;
                        end
                    end else if (credit_ok) begin
                        mem_req = 1'b1;
                        if (mem_rdy) begin
                            acc  = 1'b1;
                            step = 1'b1;
                        end
                    end
                    if (step) begin
                        issued_d = issued_q + 32'd1;
                        if (issued_q + 32'd1 == cnt_q)
                            state_d = RDRN;
                    end
                end
            end
            RDRN: begin
                if (rd_left_q == '0)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (step)
            wadr_d = wadr_q + MAW'(1);

        pop = (fcnt_q != '0);
        if (pop) begin
            ack_rd_d  = 1'b1;
            rdt_d     = fifo_q[rptr_q];
            rptr_d    = rptr_q + PW'(1);
            rd_left_d = rd_left_q - 32'd1;
        end

        push = rd_push || fake_push;
        if (push) begin
            fifo_d[wptr_q] = fake_push ? 64'h0 : mem_rdt;
            wptr_d         = wptr_q + PW'(1);
        end

        fcnt_d  = fcnt_q + CW'(push) - CW'(pop);
        outst_d = outst_q + CW'(acc) - CW'(rd_push);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            gnt_q     <= 1'b0;
            wadr_q    <= '0;
            cnt_q     <= '0;
            issued_q  <= '0;
            rd_left_q <= '0;
            outst_q   <= '0;
            fcnt_q    <= '0;
            wptr_q    <= '0;
            rptr_q    <= '0;
            fifo_q    <= '{default: '0};
            rdt_q     <= '0;
            ack_rd_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            wadr_q    <= wadr_d;
            cnt_q     <= cnt_d;
            issued_q  <= issued_d;
            rd_left_q <= rd_left_d;
            outst_q   <= outst_d;
            fcnt_q    <= fcnt_d;
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            fifo_q    <= fifo_d;
            rdt_q     <= rdt_d;
            ack_rd_q  <= ack_rd_d;
        end
    end

`ifdef NPC_BUS_RANGE_EN
    logic base_err_q, base_err_d;
    logic wrap_q, wrap_d;
    logic bus_err_q, bus_err_d;
    logic unused_sig;

    assign beat_err   = base_err_q || wrap_q;
    assign unused_sig = ^npc_adr[2:0];

    always_comb begin
        base_err_d = base_err_q;
        wrap_d     = wrap_q;
        bus_err_d  = bus_err_q || err_hit;
        if (state_q == IDLE && npc_req && !gnt_q) begin
            base_err_d = |npc_adr[31:MAW+3];
            wrap_d     = 1'b0;
        end else if (step && wadr_q == '1) begin
            wrap_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            base_err_q <= 1'b0;
            wrap_q     <= 1'b0;
            bus_err_q  <= 1'b0;
        end else begin
            base_err_q <= base_err_d;
            wrap_q     <= wrap_d;
            bus_err_q  <= bus_err_d;
        end
    end

    assign bus_err = bus_err_q;
`else
    logic unused_sig;

    assign beat_err   = 1'b0;
    assign unused_sig = ^{npc_adr[31:MAW+3], npc_adr[2:0], err_hit};
`endif

    assign npc_gnt = gnt_q;
    assign npc_rdt = rdt_q;
    assign mem_adr = wadr_q;
    assign bus_bsy = (state_q != IDLE);

endmodule

// File: tb/tb_npc_bus.sv
// Scoreboard bench for npc_bus: core-side burst driver, randomized memory responder,
// and a negedge monitor checking memory writes and read-return data against a reference memory.
module tb_npc_bus;
    localparam int MAW    = 14;
    localparam int RDEPTH = 4;
    localparam int MEMW   = 1 << MAW;
    localparam int M_IDLE = 0;
    localparam int M_WR   = 1;
    localparam int M_RD   = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic            npc_req, npc_gnt, npc_rwn, npc_ack;
    logic [31:0]     npc_adr, npc_len;
    logic [63:0]     npc_wdt, npc_rdt;
    logic            mem_req, mem_we, mem_rdy, mem_rvld, bus_bsy;
    logic [MAW-1:0]  mem_adr;
    logic [63:0]     mem_wdt, mem_rdt;

    npc_bus #(.MAW(MAW), .RDEPTH(RDEPTH)) dut (
        .clk(clk), .rst(rst),
        .npc_req(npc_req), .npc_gnt(npc_gnt), .npc_rwn(npc_rwn),
        .npc_adr(npc_adr), .npc_len(npc_len), .npc_wdt(npc_wdt),
        .npc_rdt(npc_rdt), .npc_ack(npc_ack),
        .mem_req(mem_req), .mem_we(mem_we), .mem_adr(mem_adr), .mem_wdt(mem_wdt),
        .mem_rdy(mem_rdy), .mem_rvld(mem_rvld), .mem_rdt(mem_rdt),
        .bus_bsy(bus_bsy)
    );

    always #5 clk = ~clk;

    typedef struct {logic [MAW-1:0] a; logic [63:0] d;} wexp_t;
    typedef struct {int t; logic [63:0] d;} ret_t;

    wexp_t       exp_wq[$];
    logic [63:0] exp_rq[$];
    ret_t        ret_q[$];
    logic [63:0] ref_mem [MEMW];
    logic [63:0] phys_mem [MEMW];

    int n_tests = 0, n_fail = 0;
    int cyc = 0, mode = M_IDLE;
    int rdy_pct = 100, lat = 1, rv_pct = 100, stall_end = 0;
    int accepted = 0, acked = 0, max_os = 0, os = 0, ack_total = 0;
    int first_ack, last_ack;
    bit quiet = 0, noise_en = 0, mon_en = 0;

    wexp_t       mon_e;
    ret_t        mon_r;
    logic        mon_xfer;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic fail(input string nm);
        n_tests++;
        n_fail++;
        $display("FAIL %s", nm);
    endtask

    function automatic logic [63:0] init_word(input int a);
        return {32'hC0DE_0000 | 32'(a), ~(32'(a) * 32'h9E37_79B9)};
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // memory responder: random ready, in-order returns after lat cycles, optional stall and noise
    initial begin
        mem_rdy  = 1'b0;
        mem_rvld = 1'b0;
        mem_rdt  = '0;
        forever begin
            @(posedge clk);
            #1;
            mem_rdy  = ($urandom_range(99) < rdy_pct);
            mem_rvld = 1'b0;
            mem_rdt  = '0;
            if (ret_q.size() > 0 && ret_q[0].t <= cyc && cyc >= stall_end &&
                $urandom_range(99) < rv_pct) begin
                mem_rvld = 1'b1;
                mem_rdt  = ret_q[0].d;
                void'(ret_q.pop_front());
            end else if (quiet && noise_en && ret_q.size() == 0 && $urandom_range(3) == 0) begin
                mem_rvld = 1'b1;
                mem_rdt  = {$urandom, $urandom};
            end
        end
    end

    // monitor / scoreboard
    always @(negedge clk) begin
        if (mon_en && !rst) begin
            mon_xfer = mem_req && mem_rdy;
            if (mon_xfer && mem_we) begin
                if (mode != M_WR || exp_wq.size() == 0) begin
                    fail("unexpected_mem_write");
                end else begin
                    mon_e = exp_wq.pop_front();
                    check("wr_adr", 64'(mem_adr), 64'(mon_e.a));
                    check("wr_data", mem_wdt, mon_e.d);
                    check("wr_ack_same_cycle", 64'(npc_ack), 64'd1);
                end
                phys_mem[mem_adr] = mem_wdt;
            end
            if (mon_xfer && !mem_we) begin
                if (mode != M_RD) fail("unexpected_mem_read");
                mon_r.t = cyc + lat;
                mon_r.d = phys_mem[mem_adr];
                ret_q.push_back(mon_r);
                accepted++;
            end
            if (npc_ack) begin
                ack_total++;
                if (mode == M_RD) begin
                    if (exp_rq.size() == 0) fail("extra_rd_ack");
                    else check("rd_data", npc_rdt, exp_rq.pop_front());
                    acked++;
                end else if (mode == M_WR) begin
                    if (!mon_xfer) fail("wr_ack_without_xfer");
                end else begin
                    fail("ack_while_idle");
                end
            end
            if (mode == M_RD && mon_xfer && !mem_we) begin
                os = accepted - acked;
                if (os > max_os) max_os = os;
                check("rd_credit", 64'(os <= RDEPTH), 64'd1);
            end
        end
    end

    task automatic burst(input logic rwn, input logic [31:0] adr, input logic [31:0] len);
        logic [63:0] wd[$];
        logic [63:0] d;
        wexp_t       e;
        int w, n, beats, gidx, gcnt;
        logic got, ack, bsy_last;
        w = int'((adr / 8) % MEMW);
        quiet = 0;
        for (int i = 0; i < int'(len); i++) begin
            if (rwn) begin
                exp_rq.push_back(ref_mem[(w + i) % MEMW]);
            end else begin
                d = {$urandom, $urandom};
                wd.push_back(d);
                ref_mem[(w + i) % MEMW] = d;
            end
        end
        @(posedge clk);
        #1;
        accepted = 0;
        acked    = 0;
        mode     = rwn ? M_RD : M_WR;
        npc_req  = 1'b1;
        npc_rwn  = rwn;
        npc_adr  = adr;
        npc_len  = len;
        if (!rwn && len != 0) begin
            npc_wdt = wd[0];
            e.a = MAW'(w);
            e.d = wd[0];
            exp_wq.push_back(e);
        end
        got = 0; beats = 0; n = 0; gidx = -1; gcnt = 0; bsy_last = 0;
        first_ack = -1; last_ack = -1;
        while ((!got || beats < int'(len)) && n < 2000) begin
            @(negedge clk);
            if (npc_gnt) begin
                gcnt++;
                if (!got) gidx = n;
                got = 1;
            end
            if (len == 0 && bus_bsy) fail("len0_bsy_asserted");
            ack = npc_ack;
            if (ack) begin
                if (first_ack < 0) first_ack = n;
                last_ack = n;
                beats++;
                if (beats == int'(len)) bsy_last = bus_bsy;
            end
            n++;
            @(posedge clk);
            #1;
            if (got) npc_req = 1'b0;
            if (!rwn && ack && beats < int'(len)) begin
                npc_wdt = wd[beats];
                e.a = MAW'((w + beats) % MEMW);
                e.d = wd[beats];
                exp_wq.push_back(e);
            end
        end
        npc_req = 1'b0;
        if (n >= 2000) fail("burst_timeout");
        check("gnt_latency", 64'(gidx), 64'd1);
        if (len != 0) check("bsy_at_last_ack", 64'(bsy_last), 64'd1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (npc_gnt) gcnt++;
            if (k == 0) check("bsy_after_burst", 64'(bus_bsy), 64'd0);
        end
        check("gnt_count", 64'(gcnt), 64'd1);
        check("exp_queues_empty", 64'(exp_rq.size() + exp_wq.size()), 64'd0);
        mode  = M_IDLE;
        quiet = 1;
    endtask

    task automatic reset_mid_read();
        int n, beats, a0;
        logic got;
        quiet = 0; lat = 5; rdy_pct = 100; rv_pct = 100;
        for (int i = 0; i < 5; i++) exp_rq.push_back(ref_mem[100 + i]);
        @(posedge clk);
        #1;
        accepted = 0; acked = 0;
        mode = M_RD; npc_req = 1'b1; npc_rwn = 1'b1; npc_adr = 32'd800; npc_len = 32'd5;
        got = 0; beats = 0; n = 0;
        while (beats < 2 && n < 500) begin
            @(negedge clk);
            if (npc_gnt) got = 1;
            if (npc_ack) beats++;
            n++;
            @(posedge clk);
            #1;
            if (got) npc_req = 1'b0;
        end
        if (n >= 500) fail("rst_test_timeout");
        rst = 1'b1;
        npc_req = 1'b0;
        @(negedge clk);
        check("rst_mid_ctrl", 64'({npc_gnt, npc_ack, mem_req, mem_we, bus_bsy}), 64'd0);
        check("rst_mid_rdt", npc_rdt, 64'd0);
        check("rst_mid_adr", 64'(mem_adr), 64'd0);
        check("rst_mid_wdt", mem_wdt, 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        mode = M_IDLE;
        exp_rq.delete();
        accepted = 0; acked = 0;
        a0 = ack_total;
        repeat (20) @(negedge clk);
        check("no_ack_after_rst", 64'(ack_total - a0), 64'd0);
        check("idle_after_rst", 64'({bus_bsy, mem_req}), 64'd0);
        ret_q.delete();
        quiet = 1;
    endtask

    initial begin
        for (int i = 0; i < MEMW; i++) begin
            ref_mem[i]  = init_word(i);
            phys_mem[i] = init_word(i);
        end
        rst = 1'b1;
        npc_req = 1'b0; npc_rwn = 1'b0; npc_adr = '0; npc_len = '0; npc_wdt = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_ctrl", 64'({npc_gnt, npc_ack, mem_req, mem_we, bus_bsy}), 64'd0);
        check("reset_rdt", npc_rdt, 64'd0);
        check("reset_adr_wdt", 64'(mem_adr) | mem_wdt, 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        mon_en = 1;
        quiet = 1;

        rdy_pct = 100;
        burst(1'b0, 32'h40, 32'd4);
        check("t1_consecutive_acks", 64'(last_ack - first_ack), 64'd3);

        lat = 3;
        burst(1'b1, 32'h0, 32'd3);

        lat = 2; max_os = 0;
        stall_end = cyc + 20;
        burst(1'b1, 32'h200, 32'd10);
        check("t3_max_outstanding", 64'(max_os), 64'(RDEPTH));

        burst(1'b1, 32'h80, 32'd0);
        burst(1'b1, 32'h80, 32'd2);

        burst(1'b0, 32'((MEMW - 1) * 8), 32'd2);
        burst(1'b1, 32'((MEMW - 1) * 8), 32'd2);

        reset_mid_read();

        noise_en = 1;
        for (int t = 0; t < 40; t++) begin
            case ($urandom_range(2))
                0: rdy_pct = 100;
                1: rdy_pct = 70;
                default: rdy_pct = 30;
            endcase
            lat    = $urandom_range(1, 6);
            rv_pct = $urandom_range(40, 100);
            burst(1'($urandom_range(1)), $urandom,
                  ($urandom_range(9) == 0) ? 32'd0 : 32'($urandom_range(1, 12)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
